// File: rtl/rr_arb_pkg.sv
// ---------------------------------------------------------------------------
// rr_arb_pkg
// Shared types and helpers for the round-robin token arbiter.
//   state_e      : arbiter FSM states (IDLE, GRANT)
//   MAX_N        : widest requester vector the helper functions handle
//   onehot_rotl  : advance a one-hot token by one position within n bits
//   onehot2bin   : binary index of a one-hot vector (0 for an all-zero vector)
// Optional feature macro used by the top level: RR_HOLD_LIMIT_EN
// ---------------------------------------------------------------------------
package rr_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   localparam int MAX_N = 32;

   // Rotate left by one inside the low n bits; bit n-1 wraps to bit 0.
   function automatic logic [MAX_N-1:0] onehot_rotl(input logic [MAX_N-1:0] vec,
                                                    input int               n);
      logic [MAX_N-1:0] r;
      int               j;
      r = '0;
      for (int i = 0; i < MAX_N; i++) begin
         j = (i + 1 >= n) ? 0 : i + 1;
         if (i < n && vec[i]) r[j] = 1'b1;
      end
      return r;
   endfunction

   // OR of set-bit indices; exact for one-hot input, 0 for zero input.
   function automatic int onehot2bin(input logic [MAX_N-1:0] vec);
      int idx;
      idx = 0;
      for (int i = 0; i < MAX_N; i++) begin
         if (vec[i]) idx = idx | i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_onehot_pick.sv
// ---------------------------------------------------------------------------
// rr_onehot_pick
// Combinational circular priority pick: returns the first set bit of
// (req & mask) scanning upward from the token position and wrapping.
// Ports:
//   req        in  [N]  request vector
//   token      in  [N]  one-hot start position of the search
//   mask       in  [N]  eligibility mask (1 = may be picked)
//   pick       out [N]  one-hot winner (0 when none)
//   pick_valid out      a winner exists
// ---------------------------------------------------------------------------
module rr_onehot_pick
   import rr_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   input  logic [N-1:0] token,
   input  logic [N-1:0] mask,
   output logic [N-1:0] pick,
   output logic         pick_valid
);

   logic [MAX_N-1:0] token_ext;
   logic [N-1:0]     cand;
   logic [2*N-1:0]   dbl;
   logic [2*N-1:0]   rot;
   int               tok_idx;
   int               sel;
   int               pos;

   assign token_ext = MAX_N'(token);

   always_comb begin
      tok_idx    = onehot2bin(token_ext);
      cand       = req & mask;
      // Doubling the vector makes the circular search a plain right shift.
      dbl        = {cand, cand};
      rot        = dbl >> tok_idx;
      sel        = 0;
      pick_valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            sel        = i;
            pick_valid = 1'b1;
         end
      end
      pos = tok_idx + sel;
      if (pos >= N) pos = pos - N;
      pick = '0;
      for (int j = 0; j < N; j++) begin
         pick[j] = pick_valid && (pos == j);
      end
   end

endmodule

// File: rtl/rr_token_arbiter.sv
// ---------------------------------------------------------------------------
// rr_token_arbiter
// Round-robin arbiter sharing one resource among N requesters. A one-hot
// token marks the highest-priority position; a grant is held until the owner
// drops its request, then the token moves past the owner and the remaining
// requests are re-arbitrated in the same edge.
// Optional feature: `define RR_HOLD_LIMIT_EN limits an owner to MAX_HOLD
// consecutive grant cycles while others wait (port list unchanged).
// Ports:
//   clk        in        rising-edge clock
//   rst        in        synchronous active-high reset
//   req        in  [N]   level requests
//   gnt        out [N]   one-hot grant (registered)
//   gnt_valid  out       |gnt
//   gnt_id     out [IDW] binary index of the granted requester
//   token      out [N]   one-hot current priority position
// ---------------------------------------------------------------------------
module rr_token_arbiter
   import rr_arb_pkg::*;
#(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8,
   localparam int IDW     = (N > 1) ? $clog2(N) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   gnt,
   output logic           gnt_valid,
   output logic [IDW-1:0] gnt_id,
   output logic [N-1:0]   token
);

   if (N < 2 || N > MAX_N) begin : g_bad_n
      $error("rr_token_arbiter: N out of range");
   end
   if (MAX_HOLD < 1) begin : g_bad_hold
      $error("rr_token_arbiter: MAX_HOLD must be >= 1");
   end

   state_e           state_q, state_d;
   logic [N-1:0]     gnt_q, gnt_d;
   logic             gnt_valid_q, gnt_valid_d;
   logic [IDW-1:0]   gnt_id_q, gnt_id_d;
   logic [N-1:0]     token_q, token_d;

   logic [MAX_N-1:0] rot_ext;
   logic [N-1:0]     rot_tok;
   logic [N-1:0]     arb_tok;
   logic [N-1:0]     arb_mask;
   logic [N-1:0]     pick;
   logic             pick_valid;
   logic             owner_req;
   logic             forced;

`ifdef RR_HOLD_LIMIT_EN
   localparam int HW = $clog2(MAX_HOLD + 1);
   logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
`endif

   // Token position just past the current owner, used on release/rotation.
   assign rot_ext   = onehot_rotl(MAX_N'(gnt_q), N);
   assign rot_tok   = rot_ext[N-1:0];
   assign owner_req = |(req & gnt_q);

`ifdef RR_HOLD_LIMIT_EN
   assign forced = (state_q == GRANT) && owner_req && (hold_cnt_q == HW'(MAX_HOLD));
`else
   assign forced = 1'b0;
`endif

   // Idle searches from the stored token; otherwise from the advanced one.
   assign arb_tok  = (state_q == IDLE) ? token_q : rot_tok;
   // A forcibly rotated owner only competes when nobody else is asking.
   assign arb_mask = forced ? ~gnt_q : '1;

   rr_onehot_pick #(.N(N)) u_pick (
      .req        (req),
      .token      (arb_tok),
      .mask       (arb_mask),
      .pick       (pick),
      .pick_valid (pick_valid)
   );

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      token_d = token_q;
`ifdef RR_HOLD_LIMIT_EN
      hold_cnt_d = hold_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               gnt_d   = pick;
               state_d = GRANT;
`ifdef RR_HOLD_LIMIT_EN
               hold_cnt_d = HW'(1);
`endif
            end
         end
         default: begin
            if (owner_req && !forced) begin
`ifdef RR_HOLD_LIMIT_EN
               hold_cnt_d = hold_cnt_q + HW'(1);
`endif
            end else begin
               token_d = rot_tok;
               if (pick_valid) begin
                  gnt_d = pick;
`ifdef RR_HOLD_LIMIT_EN
                  hold_cnt_d = HW'(1);
`endif
               end else if (forced) begin
                  gnt_d = gnt_q;
`ifdef RR_HOLD_LIMIT_EN
                  hold_cnt_d = HW'(1);
`endif
               end else begin
                  gnt_d   = '0;
                  state_d = IDLE;
`ifdef RR_HOLD_LIMIT_EN
                  hold_cnt_d = '0;
`endif
               end
            end
         end
      endcase
      gnt_valid_d = |gnt_d;
      gnt_id_d    = IDW'(onehot2bin(MAX_N'(gnt_d)));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         gnt_valid_q <= 1'b0;
         gnt_id_q    <= '0;
         token_q     <= N'(1);
`ifdef RR_HOLD_LIMIT_EN
         hold_cnt_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gnt_valid_q <= gnt_valid_d;
         gnt_id_q    <= gnt_id_d;
         token_q     <= token_d;
`ifdef RR_HOLD_LIMIT_EN
         hold_cnt_q  <= hold_cnt_d;
`endif
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = gnt_valid_q;
   assign gnt_id    = gnt_id_q;
   assign token     = token_q;

endmodule

// File: tb/tb_rr_token_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_token_arbiter
// Directed scoreboard bench for rr_token_arbiter (N=4, MAX_HOLD=8).
// The driver applies one vector per cycle and queues the hand-computed
// outputs expected after the next rising edge; a monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_rr_token_arbiter;

   localparam int N = 4;

   logic         clk;
   logic         rst;
   logic [N-1:0] req;
   logic [N-1:0] gnt;
   logic         gnt_valid;
   logic [1:0]   gnt_id;
   logic [N-1:0] token;

   typedef struct {
      logic [N-1:0] gnt;
      logic [N-1:0] token;
      string        tag;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   rr_token_arbiter #(.N(N), .MAX_HOLD(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id),
      .token     (token)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [1:0] idx_of(input logic [N-1:0] v);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < N; i++) if (v[i]) r = 2'(i);
      return r;
   endfunction

   task automatic check4(input string tag, input string what,
                         input logic [N-1:0] act, input logic [N-1:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s.%s got=%b want=%b", tag, what, act, want);
      end
   endtask

   // Monitor: outputs settle just after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check4(e.tag, "gnt",       gnt,               e.gnt);
            check4(e.tag, "token",     token,             e.token);
            check4(e.tag, "gnt_valid", {3'b000, gnt_valid}, {3'b000, |e.gnt});
            check4(e.tag, "gnt_id",    {2'b00, gnt_id},   {2'b00, idx_of(e.gnt)});
         end
      end
   end

   task automatic step(input string tag, input logic r, input logic [N-1:0] rq,
                       input logic [N-1:0] eg, input logic [N-1:0] et);
      exp_t e;
      @(negedge clk);
      rst = r;
      req = rq;
      e.gnt   = eg;
      e.token = et;
      e.tag   = tag;
      exp_q.push_back(e);
   endtask

   initial begin
      rst = 1'b1;
      req = '0;

      // 1. reset state
      step("rst0", 1, 4'b0000, 4'b0000, 4'b0001);
      step("rst1", 1, 4'b0000, 4'b0000, 4'b0001);
      step("idle", 0, 4'b0000, 4'b0000, 4'b0001);

      // 2. single requester, then release
      step("one",  0, 4'b0100, 4'b0100, 4'b0001);
      step("rel",  0, 4'b0000, 4'b0000, 4'b1000);

      // 3. all requesting, back-to-back rotation
      step("r3",   1, 4'b0000, 4'b0000, 4'b0001);
      step("a0",   0, 4'b1111, 4'b0001, 4'b0001);
      step("a0h",  0, 4'b1111, 4'b0001, 4'b0001);
      step("a1",   0, 4'b1110, 4'b0010, 4'b0010);
      step("a1h",  0, 4'b1110, 4'b0010, 4'b0010);
      step("a2",   0, 4'b1100, 4'b0100, 4'b0100);
      step("a2h",  0, 4'b1100, 4'b0100, 4'b0100);
      step("a3",   0, 4'b1000, 4'b1000, 4'b1000);
      step("a3h",  0, 4'b1000, 4'b1000, 4'b1000);
      step("aend", 0, 4'b0000, 4'b0000, 4'b0001);

      // 4. wrap-around from token=1000
      step("w0",   0, 4'b0100, 4'b0100, 4'b0001);
      step("w1",   0, 4'b0000, 4'b0000, 4'b1000);
      step("wrap", 0, 4'b0011, 4'b0001, 4'b1000);
      step("wrph", 0, 4'b0011, 4'b0001, 4'b1000);
      step("wrel", 0, 4'b0010, 4'b0010, 4'b0010);

      // 5. reset mid-grant
      step("mg",   0, 4'b1111, 4'b0010, 4'b0010);
      step("mrst", 1, 4'b1111, 4'b0000, 4'b0001);
      step("mpost",0, 4'b1111, 4'b0001, 4'b0001);

      // 6. long holds
      step("d0",   0, 4'b0000, 4'b0000, 4'b0010);
      step("r6",   1, 4'b0000, 4'b0000, 4'b0001);
`ifdef RR_HOLD_LIMIT_EN
      for (int k = 0; k < 32; k++) begin
         logic [N-1:0] tk;
         case (k / 8)
            0:       tk = 4'b0001;
            1:       tk = 4'b0010;
            2:       tk = 4'b0100;
            default: tk = 4'b0010;
         endcase
         step("hold2", 0, 4'b0011, ((k / 8) % 2 == 0) ? 4'b0001 : 4'b0010, tk);
      end
      for (int k = 0; k < 12; k++) begin
         step("hold1", 0, 4'b0001, 4'b0001, (k < 8) ? 4'b0100 : 4'b0010);
      end
`else
      for (int k = 0; k < 32; k++) begin
         step("hold2", 0, 4'b0011, 4'b0001, 4'b0001);
      end
      for (int k = 0; k < 12; k++) begin
         step("hold1", 0, 4'b0001, 4'b0001, 4'b0001);
      end
`endif
      step("fin",  0, 4'b0000, 4'b0000, 4'b0010);

      repeat (3) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain left=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
